fp_vec_mul_pipe: RTL and testbench

Parametrised, pipelined, multi-lane IEEE-754-style floating-point multiplier for the vector datapath. It accepts LANES operand pairs per transfer over a valid/ready handshake. Each lane is fully normalised and rounded (round-to-nearest-even), special values are handled, and per-lane exception flags are reported. It supersedes the single-lane combinational multiplier, which had no rounding, normalisation, flow control or special-value handling.

---
 rtl/fp_vec_mul_pipe.sv | 169 ++++++++++++++++
 tb/tb_fp_vec_mul_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_vec_mul_pipe.sv
// Multi-lane pipelined floating-point multiplier: unpack/classify, mantissa multiply, normalise/round/pack.
// Each lane rounds to nearest even, flushes subnormals to zero, and reports {invalid, overflow, underflow, inexact}.
`timescale 1ns/1ps
module fp_vec_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned LANES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_p,
  output logic [LANES*4-1:0]               out_flags
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned PW   = 2*MAN_W + 2;
  localparam int unsigned CW   = W + 5;
  localparam int unsigned BIAS = (2**(EXP_W-1)) - 1;
  localparam int unsigned EMAX = (2**EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Special-value resolution: returns {is_special, flags, result}.
  function automatic logic [CW-1:0] classify(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, spec;
    logic [3:0]       flg;
    logic [W-1:0]     res;
    ea     = a[W-2 -: EXP_W];
    eb     = b[W-2 -: EXP_W];
    ma     = a[MAN_W-1:0];
    mb     = b[MAN_W-1:0];
    sgn    = a[W-1] ^ b[W-1];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    spec   = 1'b1;
    flg    = 4'b0000;
    res    = '0;
    if (a_nan || b_nan) begin
      res    = QNAN;
      flg[3] = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res    = QNAN;
      flg[3] = 1'b1;
    end else if (a_inf || b_inf) begin
      res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
    return {spec, flg, res};
  endfunction

  // Normalise, round to nearest even and pack a finite product: returns {flags, result}.
  function automatic logic [W+3:0] round_pack(input logic sgn, input logic [EW-1:0] e,
                                              input logic [PW-1:0] p);
    logic [MAN_W-1:0]       man;
    logic [MAN_W:0]         man_r;
    logic                   guard, sticky, rup;
    logic signed [EW-1:0]   ex;
    logic [3:0]             flg;
    logic [W-1:0]           res;
    if (p[PW-1]) begin
      man    = p[PW-2 -: MAN_W];
      guard  = p[MAN_W];
      sticky = |p[MAN_W-1:0];
      ex     = $signed(e + EW'(1));
    end else begin
      man    = p[PW-3 -: MAN_W];
      guard  = p[MAN_W-1];
      sticky = |p[MAN_W-2:0];
      ex     = $signed(e);
    end
    rup   = guard & (sticky | man[0]);
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, rup};
    if (man_r[MAN_W]) ex = ex + EW'(1);
    flg = {3'b000, guard | sticky};
    if (ex >= $signed(EW'(EMAX))) begin
      res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end else if (ex <= $signed(EW'(0))) begin
      res = {sgn, {(W-1){1'b0}}};
      flg = 4'b0011;
    end else begin
      res = {sgn, ex[EXP_W-1:0], man_r[MAN_W-1:0]};
    end
    return {flg, res};
  endfunction

  logic                en;
  logic                v1, v2;
  logic [LANES-1:0]    s1_sign, s2_sign;
  logic [EW-1:0]       s1_exp  [LANES];
  logic [EW-1:0]       s2_exp  [LANES];
  logic [MAN_W:0]      s1_ma   [LANES];
  logic [MAN_W:0]      s1_mb   [LANES];
  logic [CW-1:0]       s1_cls  [LANES];
  logic [CW-1:0]       s2_cls  [LANES];
  logic [PW-1:0]       s2_prod [LANES];
  logic [W+3:0]        s3_rp   [LANES];
  logic [LANES*W-1:0]  s3_p;
  logic [LANES*4-1:0]  s3_f;

  // Single global advance: every stage moves together, or all hold.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_flags <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      out_p     <= v2 ? s3_p : '0;
      out_flags <= v2 ? s3_f : '0;
    end
  end

  // Datapath stages load only when their incoming slot carries data.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid) begin
          s1_sign[i] <= in_a[i*W + W - 1] ^ in_b[i*W + W - 1];
          s1_exp[i]  <= EW'(in_a[i*W + MAN_W +: EXP_W]) + EW'(in_b[i*W + MAN_W +: EXP_W])
                        - EW'(BIAS);
          s1_ma[i]   <= {1'b1, in_a[i*W +: MAN_W]};
          s1_mb[i]   <= {1'b1, in_b[i*W +: MAN_W]};
          s1_cls[i]  <= classify(in_a[i*W +: W], in_b[i*W +: W]);
        end
        if (v1) begin
          s2_sign[i] <= s1_sign[i];
          s2_exp[i]  <= s1_exp[i];
          s2_cls[i]  <= s1_cls[i];
          s2_prod[i] <= PW'(s1_ma[i]) * PW'(s1_mb[i]);
        end
      end
    end
  end

  always_comb begin
    s3_rp = '{default: '0};
    s3_p  = '0;
    s3_f  = '0;
    for (int i = 0; i < LANES; i++) begin
      s3_rp[i] = s2_cls[i][CW-1] ? s2_cls[i][W+3:0]
                                 : round_pack(s2_sign[i], s2_exp[i], s2_prod[i]);
      s3_p[i*W +: W] = s3_rp[i][W-1:0];
      s3_f[i*4 +: 4] = s3_rp[i][W+3:W];
    end
  end

endmodule

// File: tb/tb_fp_vec_mul_pipe.sv
// Directed self-checking bench for fp_vec_mul_pipe (LANES=4, binary32 lanes).
`timescale 1ns/1ps
module tb_fp_vec_mul_pipe;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned LANES = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_p;
  logic [15:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_vec_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_flags(out_flags)
  );

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Send one vector with out_ready high and capture the first result (bounded wait).
  task automatic run_one(input logic [127:0] a, input logic [127:0] b,
                         output logic [127:0] p, output logic [15:0] f, output bit got);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    got = 1'b0;
    p   = '0;
    f   = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (out_valid) begin
        p   = out_p;
        f   = out_flags;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_p !== '0) begin n_bad++; $display("FAIL reset_out_p: got %h expected 0", out_p); end
    n_cmp++; if (out_flags !== '0) begin n_bad++; $display("FAIL reset_out_flags: got %h expected 0", out_flags); end
    reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    logic [31:0] xp [4];
    xp = '{32'h40400000, 32'h40800000, 32'hBF800000, 32'h3F800000};
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = pack4(32'h3FC00000, 32'h40000000, 32'hC0000000, 32'h3F800000);
    in_b = pack4(32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== (k == 3)) begin
        n_bad++; $display("FAIL latency_cycle%0d: out_valid got %b expected %b", k, out_valid, (k == 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_p[i*32 +: 32] !== xp[i]) begin n_bad++; $display("FAIL basic_p lane%0d: got %h expected %h", i, out_p[i*32 +: 32], xp[i]); end
    end
    n_cmp++; if (out_flags !== 16'h0) begin n_bad++; $display("FAIL basic_flags: got %h expected 0000", out_flags); end
  endtask

  task automatic test_lanes();
    logic [127:0] p;
    logic [15:0]  f;
    bit           got;
    logic [31:0]  xp [4];
    logic [3:0]   xf [4];
    xp = '{32'h7F800000, 32'h00000000, 32'hBF800000, 32'h41100000};
    xf = '{4'b0101, 4'b0011, 4'b0000, 4'b0000};
    run_one(pack4(32'h7F000000, 32'h00800000, 32'h3F800000, 32'h40400000),
            pack4(32'h7F000000, 32'h00800000, 32'hBF800000, 32'h40400000), p, f, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL lanes_timeout: got no out_valid expected one within 10 cycles"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (p[i*32 +: 32] !== xp[i]) begin n_bad++; $display("FAIL lanes_p lane%0d: got %h expected %h", i, p[i*32 +: 32], xp[i]); end
      n_cmp++; if (f[i*4 +: 4] !== xf[i]) begin n_bad++; $display("FAIL lanes_flags lane%0d: got %b expected %b", i, f[i*4 +: 4], xf[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [127:0] p;
    logic [15:0]  f;
    bit           got;
    logic [31:0]  xp [4];
    logic [3:0]   xf [4];
    xp = '{32'h3F800002, 32'h3FC00004, 32'h3FC00002, 32'h407FFFFE};
    xf = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    run_one(pack4(32'h3F800001, 32'h3F800003, 32'h3F800001, 32'h3FFFFFFF),
            pack4(32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF), p, f, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL round_timeout: got no out_valid expected one within 10 cycles"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (p[i*32 +: 32] !== xp[i]) begin n_bad++; $display("FAIL round_p lane%0d: got %h expected %h", i, p[i*32 +: 32], xp[i]); end
      n_cmp++; if (f[i*4 +: 4] !== xf[i]) begin n_bad++; $display("FAIL round_flags lane%0d: got %b expected %b", i, f[i*4 +: 4], xf[i]); end
    end
  endtask

  task automatic test_specials();
    logic [127:0] p;
    logic [15:0]  f;
    bit           got;
    logic [127:0] va [2];
    logic [127:0] vb [2];
    logic [31:0]  xp [8];
    logic [3:0]   xf [8];
    va[0] = pack4(32'h7F800000, 32'h7F800001, 32'h7FC00000, 32'h80000000);
    vb[0] = pack4(32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000);
    va[1] = pack4(32'hFF800000, 32'h00000001, 32'h00400000, 32'h7F800000);
    vb[1] = pack4(32'h40000000, 32'h7F800000, 32'h3F800000, 32'h7F800000);
    xp = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
           32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h7F800000};
    xf = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    for (int v = 0; v < 2; v++) begin
      run_one(va[v], vb[v], p, f, got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL spec_timeout vec%0d: got no out_valid expected one within 10 cycles", v); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (p[i*32 +: 32] !== xp[v*4+i]) begin n_bad++; $display("FAIL spec_p vec%0d lane%0d: got %h expected %h", v, i, p[i*32 +: 32], xp[v*4+i]); end
        n_cmp++; if (f[i*4 +: 4] !== xf[v*4+i]) begin n_bad++; $display("FAIL spec_flags vec%0d lane%0d: got %b expected %b", v, i, f[i*4 +: 4], xf[v*4+i]); end
      end
    end
  endtask

  // Ten distinct vectors times {1,1,1,-1}; out_ready low for five cycles mid-stream.
  task automatic test_back_to_back();
    logic [127:0] va [10];
    logic [127:0] xp [10];
    logic [127:0] vb;
    logic [127:0] held;
    int           tx, rx;
    bit           acc, stalled;
    vb = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) va[k][j*32 +: 32] = 32'h40000000 | 32'(k << 8) | 32'(j);
      xp[k] = va[k];
      xp[k][127] = 1'b1;
    end
    tx = 0; rx = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (tx < 10);
      if (tx < 10) in_a = va[tx];
      in_b = vb;
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_bad++; $display("FAIL b2b_in_ready cyc%0d: got %b expected %b", cyc, in_ready, (!out_valid || out_ready));
      end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_p !== held) begin
          n_bad++; $display("FAIL b2b_hold cyc%0d: got valid=%b p=%h expected valid=1 p=%h", cyc, out_valid, out_p, held);
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_p !== xp[rx] || out_flags !== 16'h0) begin
          n_bad++; $display("FAIL b2b_result%0d: got p=%h f=%h expected p=%h f=0000", rx, out_p, out_flags, xp[rx]);
        end
        rx++;
      end
      stalled = out_valid && !out_ready;
      held    = out_p;
      @(posedge clk);
      if (acc) tx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (rx != 10) begin n_bad++; $display("FAIL b2b_count: got %0d results expected 10", rx); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_dup cyc%0d: got out_valid %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = pack4(32'h3F800000 + 32'(k), 32'h40000000, 32'h40400000, 32'h40800000);
      in_b = pack4(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_p !== '0) begin n_bad++; $display("FAIL flush_out_p: got %h expected 0", out_p); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale cyc%0d: got out_valid %b expected 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lanes();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
